// File: rtl/rr_hold_arbiter.sv
// Round-robin merge of WIDTH FWFT sources into one word stream; a source holding HOLD_REQ keeps the grant.
// Grant 1 cycle after request (IDLE->LOCK), word registered 1 cycle after grant; READY_OUT low stalls without losing the lock.
module rr_hold_arbiter #(
  parameter int WIDTH        = 6,
  parameter int DSIZE        = 32,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST,
  input  logic [WIDTH-1:0]       WRITE_REQ,
  input  logic [WIDTH-1:0]       HOLD_REQ,
  input  logic [WIDTH*DSIZE-1:0] DATA_IN,
  output logic [WIDTH-1:0]       READ_GRANT,
  input  logic                   READY_OUT,
  output logic                   WRITE_OUT,
  output logic [DSIZE-1:0]       DATA_OUT,
  output logic                   HOLD_TO
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(WIDTH - 1);
  localparam logic [CW-1:0] TO_MAX   = CW'(HOLD_TIMEOUT);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cur_q, cur_d, last_q, last_d, nxt, idx;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic            hold_to_d, found, xfer, cur_req, cur_hold, timeout;

  // Rotating priority: scan starts one past the last winner and wraps.
  always_comb begin
    nxt   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int k = 1; k <= WIDTH; k++) begin
      idx = IW'((int'(last_q) + k) % WIDTH);
      if (!found && WRITE_REQ[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign cur_req  = WRITE_REQ[cur_q];
  assign cur_hold = HOLD_REQ[cur_q];
  assign timeout  = (to_cnt_q == TO_MAX);
  assign xfer     = (state_q == LOCK) & READY_OUT & cur_req & ~BUS_RST;

  always_comb begin
    READ_GRANT = '0;
    if (xfer) READ_GRANT[cur_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    to_cnt_d  = to_cnt_q;
    hold_to_d = HOLD_TO;
    case (state_q)
      IDLE: begin
        if (|WRITE_REQ) begin
          state_d  = LOCK;
          cur_d    = nxt;
          last_d   = nxt;
          to_cnt_d = '0;
        end
      end
      LOCK: begin
        // Only an empty holder ages toward the timeout; a READY_OUT stall does not.
        if (xfer)
          to_cnt_d = '0;
        else if (!cur_req && cur_hold && !timeout)
          to_cnt_d = to_cnt_q + 1'b1;
        if (timeout)
          hold_to_d = 1'b1;
        if ((xfer && !cur_hold) || (!cur_req && !cur_hold) || timeout)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      last_q    <= LAST_RST;
      to_cnt_q  <= '0;
      HOLD_TO   <= 1'b0;
      WRITE_OUT <= 1'b0;
      DATA_OUT  <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      to_cnt_q  <= to_cnt_d;
      HOLD_TO   <= hold_to_d;
      WRITE_OUT <= xfer;
      if (xfer) DATA_OUT <= DATA_IN[int'(cur_q)*DSIZE +: DSIZE];
    end
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_rr_hold_arbiter;
  localparam int W  = 6;
  localparam int D  = 32;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   wr_v, hold_d, gnt;
  logic [W*D-1:0] din;
  logic           rdy, wout, hto;
  logic [D-1:0]   dout;

  always #5 clk = ~clk;

  rr_hold_arbiter #(.WIDTH(W), .DSIZE(D), .HOLD_TIMEOUT(TO)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .WRITE_REQ(wr_v), .HOLD_REQ(hold_d),
    .DATA_IN(din), .READ_GRANT(gnt), .READY_OUT(rdy), .WRITE_OUT(wout),
    .DATA_OUT(dout), .HOLD_TO(hto)
  );

  // Source FWFT FIFOs as circular buffers; words are {source, sequence}.
  logic [31:0] fmem [W][32];
  int fhead[W], fcnt[W], push_seq[W], out_seq[W];
  int out_src[$];
  logic [W-1:0] hold_v;
  bit auto_hold0;
  int n_chk, n_pass;

  // Reference model state
  bit m_locked, e_wout, e_hto;
  int m_cur, m_last, m_idle;
  logic [31:0] e_dout;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(int s, int n);
    for (int k = 0; k < n; k++) begin
      if (fcnt[s] < 16) begin
        fmem[s][(fhead[s] + fcnt[s]) % 32] = {8'(s), 24'(push_seq[s])};
        push_seq[s]++;
        fcnt[s]++;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      wr_v[i] = (fcnt[i] != 0);
      din[i*D +: D] = wr_v[i] ? fmem[i][fhead[i]] : $urandom();
    end
    hold_d = hold_v;
    if (auto_hold0) hold_d[0] = (fcnt[0] > 1);
  endtask

  // One clock edge of the arbiter as described by its rules.
  task automatic model_step();
    bit x, done, found;
    if (rst) begin
      m_locked = 0; m_last = W - 1; m_cur = 0; m_idle = 0;
      e_wout = 0; e_dout = 0; e_hto = 0;
    end else if (!m_locked) begin
      e_wout = 0;
      found  = 0;
      for (int k = 1; k <= W; k++) begin
        int j;
        j = (m_last + k) % W;
        if (!found && wr_v[j]) begin
          found = 1; m_cur = j; m_last = j;
        end
      end
      if (found) begin
        m_locked = 1; m_idle = 0;
      end
    end else begin
      x      = rdy && wr_v[m_cur];
      e_wout = x;
      if (x) e_dout = fmem[m_cur][fhead[m_cur]];
      done = (x && !hold_d[m_cur]) || (!wr_v[m_cur] && !hold_d[m_cur]) || (m_idle == TO);
      if (m_idle == TO) e_hto = 1;
      if (x) m_idle = 0;
      else if (!wr_v[m_cur] && hold_d[m_cur] && m_idle < TO) m_idle++;
      if (done) m_locked = 0;
    end
  endtask

  task automatic cycle();
    logic [W-1:0] g_obs;
    int s;
    drive();
    @(negedge clk);
    g_obs = gnt;
    check("grant", gnt, (m_locked && rdy && wr_v[m_cur] && !rst) ? (32'(1) << m_cur) : 32'(0));
    check("onehot", 32'($onehot0(gnt)), 32'(1));
    @(posedge clk);
    #1;
    model_step();
    check("write_out", wout, e_wout);
    if (e_wout) check("data_out", dout, e_dout);
    check("hold_to", hto, e_hto);
    if (wout) begin
      s = int'(dout[31:24]);
      out_src.push_back(s);
      if (s < W) begin
        check("src_order", dout[23:0], out_seq[s]);
        out_seq[s] = int'(dout[23:0]) + 1;
      end else begin
        check("src_range", s, W - 1);
      end
    end
    for (int i = 0; i < W; i++) begin
      if (g_obs[i] && fcnt[i] != 0) begin
        fhead[i] = (fhead[i] + 1) % 32;
        fcnt[i]--;
      end
    end
  endtask

  task automatic drain(int max_cyc);
    int left;
    for (int c = 0; c < max_cyc; c++) begin
      left = 0;
      for (int i = 0; i < W; i++) left += fcnt[i];
      if (left == 0 && !m_locked) break;
      cycle();
    end
    left = 0;
    for (int i = 0; i < W; i++) left += fcnt[i];
    check("drain", left + int'(m_locked), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; rdy = 1; hold_v = '0; auto_hold0 = 0;
    m_locked = 0; m_last = W - 1; m_cur = 0; m_idle = 0;
    e_wout = 0; e_dout = 0; e_hto = 0;
    drive();
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 0;

    // Two plain sources alternate
    out_src.delete();
    push(1, 4); push(2, 4);
    drain(100);
    check("t1_count", out_src.size(), 8);
    for (int k = 0; k < out_src.size() && k < 8; k++)
      check("t1_src", out_src[k], (k % 2 == 0) ? 1 : 2);

    // Three-word held record from source 0 is not interleaved
    out_src.delete();
    auto_hold0 = 1;
    push(0, 3);
    cycle();
    push(3, 2);
    drain(100);
    auto_hold0 = 0;
    check("t2_count", out_src.size(), 5);
    for (int k = 0; k < out_src.size() && k < 5; k++)
      check("t2_src", out_src[k], (k < 3) ? 0 : 3);

    // Empty holder times out, sticky flag set
    out_src.delete();
    hold_v = 6'b000001;
    push(0, 1); push(5, 2);
    drain(100);
    hold_v = '0;
    check("t3_hold_to", hto, 1);
    check("t3_count", out_src.size(), 3);
    for (int k = 0; k < out_src.size() && k < 3; k++)
      check("t3_src", out_src[k], (k == 1) ? 0 : 5);

    // Downstream stall keeps the lock and loses nothing
    out_src.delete();
    rdy = 0;
    push(1, 2); push(4, 2);
    repeat (10) cycle();
    check("t4_stalled", out_src.size(), 0);
    rdy = 1;
    drain(100);
    check("t4_count", out_src.size(), 4);
    if (out_src.size() > 0) check("t4_first", out_src[0], 1);

    // Reset lands on a cycle with a transfer pending
    out_src.delete();
    push(2, 3); push(4, 1);
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    check("t5_hold_to_clr", hto, 0);
    drain(100);
    check("t5_count", out_src.size(), 4);
    if (out_src.size() > 0) check("t5_first", out_src[0], 2);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      rdy    = ($urandom_range(0, 3) != 0);
      hold_v = W'($urandom());
      rst    = ($urandom_range(0, 499) == 0);
      for (int s = 0; s < W; s++)
        if ($urandom_range(0, 9) < 3) push(s, 1);
      cycle();
    end
    rst = 0; hold_v = '0; rdy = 1;
    drain(1000);
    for (int s = 0; s < W; s++) check("t6_all_delivered", out_seq[s], push_seq[s]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
